ddr3_app_bridge: RTL and testbench

- Bridges the CPU data-memory request port onto the DDR3 controller user (app) interface.
- Sits directly upstream of the DDR3 memory controller inside cpu_top, which drives the ddr3_* pins.
- Converts single 32-bit word accesses into 128-bit app bursts: byte-masked writes, lane-selected reads.
- Holds off all traffic until calibration completes and reports read timeouts as errors.

---
 rtl/ddr3_app_bridge_pkg.sv | 28 ++
 rtl/ddr3_app_bridge_if.sv | 61 ++++++
 rtl/ddr3_app_bridge_lane_mux.sv | 35 +++
 rtl/ddr3_app_bridge.sv | 185 ++++++++++++++++++
 tb/tb_ddr3_app_bridge.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr3_app_bridge_pkg.sv
//------------------------------------------------------------------------------
// Module   : ddr_bridge_pkg
// Purpose  : Shared constants and FSM state type for the CPU-to-DDR3 app bridge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ddr_bridge_pkg;

  // Controller app_cmd encodings
  localparam logic [2:0]  APP_CMD_WR = 3'b000;
  localparam logic [2:0]  APP_CMD_RD = 3'b001;

  // Read data returned alongside a timeout error
  localparam logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF;

  // Bridge sequencing states
  typedef enum logic [2:0] {
    WAIT_CAL = 3'd0,
    IDLE     = 3'd1,
    WR       = 3'd2,
    RD       = 3'd3,
    RD_WAIT  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ddr3_app_bridge_if.sv
//------------------------------------------------------------------------------
// Module   : ddr3_app_bridge_if
// Purpose  : CPU request/response port plus DDR3 controller app port, bundled.
//            The bridge uses the slave modport; its environment uses master.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ddr3_app_bridge_if #(
  parameter int ADDR_W     = 28,
  parameter int APP_DATA_W = 128
);

  // Controller status
  logic                    calib_done_i;

  // CPU request / response
  logic                    req_valid_i;
  logic                    req_ready_o;
  logic                    req_we_i;
  logic [31:0]             req_addr_i;
  logic [31:0]             req_wdata_i;
  logic [3:0]              req_be_i;
  logic                    resp_valid_o;
  logic [31:0]             resp_rdata_o;
  logic                    resp_err_o;

  // Controller app interface
  logic [ADDR_W-1:0]       app_addr_o;
  logic [2:0]              app_cmd_o;
  logic                    app_en_o;
  logic                    app_rdy_i;
  logic [APP_DATA_W-1:0]   app_wdf_data_o;
  logic                    app_wdf_wren_o;
  logic                    app_wdf_end_o;
  logic [APP_DATA_W/8-1:0] app_wdf_mask_o;
  logic                    app_wdf_rdy_i;
  logic [APP_DATA_W-1:0]   app_rd_data_i;
  logic                    app_rd_data_valid_i;

  // Environment side: CPU + controller model
  modport master (
    output calib_done_i, req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
           app_rdy_i, app_wdf_rdy_i, app_rd_data_i, app_rd_data_valid_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           app_addr_o, app_cmd_o, app_en_o, app_wdf_data_o, app_wdf_wren_o,
           app_wdf_end_o, app_wdf_mask_o
  );

  // Bridge side
  modport slave (
    input  calib_done_i, req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
           app_rdy_i, app_wdf_rdy_i, app_rd_data_i, app_rd_data_valid_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           app_addr_o, app_cmd_o, app_en_o, app_wdf_data_o, app_wdf_wren_o,
           app_wdf_end_o, app_wdf_mask_o
  );

endinterface

`default_nettype wire

// File: rtl/ddr3_app_bridge_lane_mux.sv
//------------------------------------------------------------------------------
// Module   : ddr3_lane_mux
// Purpose  : Maps one 32-bit CPU word onto a 128-bit app burst: replicates the
//            write word into every lane, builds the byte mask that only opens
//            the selected lane, and picks the selected lane out of read data.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ddr3_lane_mux #(
  parameter int APP_DATA_W = 128
) (
  input  wire  [1:0]              lane,
  input  wire  [31:0]             wdata,
  input  wire  [3:0]              be,
  input  wire  [APP_DATA_W-1:0]   rd_data,
  output logic [APP_DATA_W-1:0]   wdf_data,
  output logic [APP_DATA_W/8-1:0] wdf_mask,
  output logic [31:0]             rd_word
);

  localparam int c_LANES = APP_DATA_W / 32;

  // Per-lane write data copy and mask; mask bit 1 means "do not write"
  for (genvar gi = 0; gi < c_LANES; gi++) begin : g_lane
    assign wdf_data[32*gi +: 32] = wdata;
    assign wdf_mask[4*gi +: 4]   = (lane == 2'(gi)) ? ~be : 4'hF;
  end

  // Selected 32-bit lane of the returned burst
  assign rd_word = rd_data[32*lane +: 32];

endmodule

`default_nettype wire

// File: rtl/ddr3_app_bridge.sv
//------------------------------------------------------------------------------
// Module   : ddr3_app_bridge
// Purpose  : Bridges single-word CPU data accesses onto the DDR3 controller app
//            interface. One request outstanding at a time; traffic is gated
//            until calibration completes; reads time out with an error.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ddr3_app_bridge
  import ddr_bridge_pkg::*;
#(
  parameter int ADDR_W     = 28,
  parameter int APP_DATA_W = 128,
  parameter int RD_TIMEOUT = 1023
) (
  input  wire              clk_i,
  input  wire              rst_i,
  ddr3_app_bridge_if.slave bus
);

  localparam int c_CNT_W = $clog2(RD_TIMEOUT + 1);

  state_t               r_state;
  logic                 r_req_ready;
  logic                 r_resp_valid;
  logic                 r_resp_err;
  logic [31:0]          r_resp_rdata;
  logic                 r_app_en;
  logic                 r_wren;
  logic [2:0]           r_app_cmd;
  logic [25:0]          r_addr;       // byte address bits [27:2]
  logic [31:0]          r_wdata;
  logic [3:0]           r_be;
  logic                 r_cmd_done;
  logic                 r_dat_done;
  logic                 r_cal_lost;   // calibration dropped while a request was in flight
  logic [c_CNT_W-1:0]   r_cnt;

  logic                 w_cmd_acc;
  logic                 w_dat_acc;
  logic                 w_cmd_done_nx;
  logic                 w_dat_done_nx;
  logic                 w_cal_ok;
  logic                 w_timeout;
  logic [31:0]          w_rd_word;
  logic                 w_unused;

  // Channel handshakes and completion terms
  assign w_cmd_acc     = r_app_en & bus.app_rdy_i;
  assign w_dat_acc     = r_wren & bus.app_wdf_rdy_i;
  assign w_cmd_done_nx = r_cmd_done | w_cmd_acc;
  assign w_dat_done_nx = r_dat_done | w_dat_acc;
  assign w_cal_ok      = bus.calib_done_i & ~r_cal_lost;
  assign w_timeout     = (r_cnt == c_CNT_W'(RD_TIMEOUT - 1));

  // Address bits outside the 256 MB window and the byte offset are not used
  assign w_unused = &{1'b0, bus.req_addr_i[31:28], bus.req_addr_i[1:0]};

  // Lane steering for the latched request
  ddr3_lane_mux #(
    .APP_DATA_W (APP_DATA_W)
  ) u_lane_mux (
    .lane     (r_addr[1:0]),
    .wdata    (r_wdata),
    .be       (r_be),
    .rd_data  (bus.app_rd_data_i),
    .wdf_data (bus.app_wdf_data_o),
    .wdf_mask (bus.app_wdf_mask_o),
    .rd_word  (w_rd_word)
  );

  // Output drive; burst address counts 16-bit DQ words, aligned to BL8
  assign bus.req_ready_o    = r_req_ready;
  assign bus.resp_valid_o   = r_resp_valid;
  assign bus.resp_err_o     = r_resp_err;
  assign bus.resp_rdata_o   = r_resp_rdata;
  assign bus.app_en_o       = r_app_en;
  assign bus.app_cmd_o      = r_app_cmd;
  assign bus.app_wdf_wren_o = r_wren;
  assign bus.app_wdf_end_o  = r_wren;
  assign bus.app_addr_o     = ADDR_W'({r_addr[25:2], 3'b000});

  // Request sequencing: calibration gate, write/read command issue, read timeout
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= WAIT_CAL;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_app_en     <= 1'b0;
      r_wren       <= 1'b0;
      r_app_cmd    <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_cmd_done   <= 1'b0;
      r_dat_done   <= 1'b0;
      r_cal_lost   <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        WAIT_CAL: begin
          r_req_ready <= 1'b0;
          if (bus.calib_done_i) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
          end
        end

        IDLE: begin
          if (bus.req_valid_i) begin
            r_addr      <= bus.req_addr_i[27:2];
            r_wdata     <= bus.req_wdata_i;
            r_be        <= bus.req_be_i;
            r_req_ready <= 1'b0;
            r_cal_lost  <= ~bus.calib_done_i;
            r_app_en    <= 1'b1;
            if (bus.req_we_i) begin
              r_state    <= WR;
              r_app_cmd  <= APP_CMD_WR;
              r_wren     <= 1'b1;
              r_cmd_done <= 1'b0;
              r_dat_done <= 1'b0;
            end else begin
              r_state   <= RD;
              r_app_cmd <= APP_CMD_RD;
            end
          end else if (!bus.calib_done_i) begin
            r_state     <= WAIT_CAL;
            r_req_ready <= 1'b0;
          end
        end

        WR: begin
          if (!bus.calib_done_i) r_cal_lost <= 1'b1;
          r_cmd_done <= w_cmd_done_nx;
          r_dat_done <= w_dat_done_nx;
          if (w_cmd_acc) r_app_en <= 1'b0;
          if (w_dat_acc) r_wren   <= 1'b0;
          if (w_cmd_done_nx && w_dat_done_nx) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_state      <= w_cal_ok ? IDLE : WAIT_CAL;
            r_req_ready  <= w_cal_ok;
            r_cal_lost   <= 1'b0;
          end
        end

        RD: begin
          if (!bus.calib_done_i) r_cal_lost <= 1'b1;
          if (w_cmd_acc) begin
            r_app_en <= 1'b0;
            r_state  <= RD_WAIT;
            r_cnt    <= '0;
          end
        end

        RD_WAIT: begin
          if (!bus.calib_done_i) r_cal_lost <= 1'b1;
          r_cnt <= r_cnt + c_CNT_W'(1);
          // Data arriving on the timeout cycle still counts as a good read
          if (bus.app_rd_data_valid_i || w_timeout) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= ~bus.app_rd_data_valid_i;
            r_resp_rdata <= bus.app_rd_data_valid_i ? w_rd_word : ERR_RDATA;
            r_state      <= w_cal_ok ? IDLE : WAIT_CAL;
            r_req_ready  <= w_cal_ok;
            r_cal_lost   <= 1'b0;
          end
        end

        default: begin
          r_state     <= WAIT_CAL;
          r_req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ddr3_app_bridge.sv
//------------------------------------------------------------------------------
// Module   : tb_ddr3_app_bridge
// Purpose  : Self-checking bench for ddr3_app_bridge with a behavioural model
//            of address mapping, lane masking, lane selection and timeouts.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ddr3_app_bridge;
  import ddr_bridge_pkg::*;

  localparam int RD_TO = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ddr3_app_bridge_if #(.ADDR_W(28), .APP_DATA_W(128)) bus ();

  ddr3_app_bridge #(
    .ADDR_W     (28),
    .APP_DATA_W (128),
    .RD_TIMEOUT (RD_TO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  // Model: burst index (16 bytes) times 8 DQ words, within a 256 MB window
  function automatic logic [27:0] m_app_addr(input logic [31:0] a);
    logic [31:0] t;
    t = ((a % 32'h1000_0000) / 32'd16) * 32'd8;
    return t[27:0];
  endfunction

  // Model: only enabled bytes of the addressed word are written
  function automatic logic [15:0] m_mask(input logic [31:0] a, input logic [3:0] be);
    logic [15:0] m;
    int          ln;
    m  = 16'hFFFF;
    ln = int'(a[3:2]);
    for (int b = 0; b < 16; b++)
      if ((b / 4) == ln && be[b % 4]) m[b] = 1'b0;
    return m;
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a, input logic [127:0] d);
    logic [127:0] s;
    s = d >> (32 * int'(a[3:2]));
    return s[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.calib_done_i        = 1'b0;
    bus.req_valid_i         = 1'b0;
    bus.req_we_i            = 1'b0;
    bus.req_addr_i          = '0;
    bus.req_wdata_i         = '0;
    bus.req_be_i            = '0;
    bus.app_rdy_i           = 1'b0;
    bus.app_wdf_rdy_i       = 1'b0;
    bus.app_rd_data_i       = '0;
    bus.app_rd_data_valid_i = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready_o === 1'b1) begin
        ok = 1'b1;
        return;
      end
      step();
    end
    total++;
    bad++;
    $display("FAIL wait_ready: req_ready_o=%b after 20 cycles, want 1", bus.req_ready_o);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) step();
    total++;
    if ({bus.req_ready_o, bus.resp_valid_o, bus.resp_err_o, bus.app_en_o,
         bus.app_wdf_wren_o, bus.app_wdf_end_o, bus.app_cmd_o} !== 9'd0) begin
      bad++;
      $display("FAIL reset_ctrl: got rdy=%b rv=%b err=%b en=%b wren=%b end=%b cmd=%b, want all 0",
               bus.req_ready_o, bus.resp_valid_o, bus.resp_err_o, bus.app_en_o,
               bus.app_wdf_wren_o, bus.app_wdf_end_o, bus.app_cmd_o);
    end
    total++;
    if (bus.app_addr_o !== 28'd0 || bus.app_wdf_data_o !== 128'd0 || bus.resp_rdata_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_data: got addr=%h data=%h rdata=%h, want 0",
               bus.app_addr_o, bus.app_wdf_data_o, bus.resp_rdata_o);
    end
    total++;
    if (bus.app_wdf_mask_o !== 16'hFFFF) begin
      bad++;
      $display("FAIL reset_mask: got %h want FFFF", bus.app_wdf_mask_o);
    end
  endtask

  task automatic test_calib_gate();
    rst_n = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      total++;
      if (bus.req_ready_o !== 1'b0 || bus.app_en_o !== 1'b0) begin
        bad++;
        $display("FAIL calib_gate cyc %0d: got rdy=%b en=%b want 0 0", i, bus.req_ready_o, bus.app_en_o);
      end
    end
    bus.req_valid_i  = 1'b0;
    bus.calib_done_i = 1'b1;
    step();
    total++;
    if (bus.req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL calib_rise: got rdy=%b want 1", bus.req_ready_o);
    end
  endtask

  // Write with independent command / data acceptance delays; drop_k >= 0
  // removes calibration at that cycle of the transaction.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input int cd, input int dd,
                          input int drop_k, input string tag);
    bit ok;
    int last;
    wait_ready(ok);
    if (!ok) return;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = data;
    bus.req_be_i    = be;
    step();
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = $urandom();
    bus.req_wdata_i = $urandom();
    bus.req_be_i    = 4'($urandom_range(0, 15));
    total++;
    if (bus.app_addr_o !== m_app_addr(addr) || bus.app_wdf_mask_o !== m_mask(addr, be) ||
        bus.app_wdf_data_o !== {4{data}} || bus.app_cmd_o !== APP_CMD_WR) begin
      bad++;
      $display("FAIL %s wr_fields: got addr=%h mask=%h data=%h cmd=%b want addr=%h mask=%h data=%h cmd=000",
               tag, bus.app_addr_o, bus.app_wdf_mask_o, bus.app_wdf_data_o, bus.app_cmd_o,
               m_app_addr(addr), m_mask(addr, be), {4{data}});
    end
    last = (cd > dd) ? cd : dd;
    for (int k = 0; k <= last + 3; k++) begin
      total++;
      if ({bus.app_en_o, bus.app_wdf_wren_o, bus.app_wdf_end_o, bus.resp_valid_o} !==
          {(k <= cd), (k <= dd), (k <= dd), (k == last + 1)}) begin
        bad++;
        $display("FAIL %s wr_cyc %0d: got en=%b wren=%b end=%b rv=%b want %b %b %b %b", tag, k,
                 bus.app_en_o, bus.app_wdf_wren_o, bus.app_wdf_end_o, bus.resp_valid_o,
                 (k <= cd), (k <= dd), (k <= dd), (k == last + 1));
      end
      if (k == last + 1) begin
        total++;
        if (bus.resp_err_o !== 1'b0 || bus.req_ready_o !== (drop_k < 0)) begin
          bad++;
          $display("FAIL %s wr_resp: got err=%b rdy=%b want err=0 rdy=%b",
                   tag, bus.resp_err_o, bus.req_ready_o, (drop_k < 0));
        end
      end
      if (k == drop_k) bus.calib_done_i = 1'b0;
      bus.app_rdy_i           = (k >= cd);
      bus.app_wdf_rdy_i       = (k >= dd);
      bus.app_rd_data_valid_i = 1'($urandom_range(0, 1));
      bus.app_rd_data_i       = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end
    bus.app_rdy_i           = 1'b0;
    bus.app_wdf_rdy_i       = 1'b0;
    bus.app_rd_data_valid_i = 1'b0;
  endtask

  // Read with command delay rd and data delay dv (cycles into the wait phase)
  task automatic do_read(input logic [31:0] addr, input int rd, input int dv, input string tag);
    bit           ok;
    int           exp_j;
    logic [127:0] burst;
    logic [32:0]  exp_resp;
    wait_ready(ok);
    if (!ok) return;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = addr;
    step();
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = $urandom();
    burst = {$urandom(), $urandom(), $urandom(), $urandom()};
    total++;
    if (bus.app_addr_o !== m_app_addr(addr) || bus.app_cmd_o !== APP_CMD_RD) begin
      bad++;
      $display("FAIL %s rd_cmd: got addr=%h cmd=%b want addr=%h cmd=001",
               tag, bus.app_addr_o, bus.app_cmd_o, m_app_addr(addr));
    end
    for (int k = 0; k <= rd; k++) begin
      total++;
      if ({bus.app_en_o, bus.resp_valid_o} !== 2'b10) begin
        bad++;
        $display("FAIL %s rd_issue %0d: got en=%b rv=%b want 1 0", tag, k, bus.app_en_o, bus.resp_valid_o);
      end
      bus.app_rdy_i = (k == rd);
      step();
    end
    bus.app_rdy_i = 1'b0;
    exp_j    = (dv + 1 < RD_TO) ? dv + 1 : RD_TO;
    exp_resp = (dv >= RD_TO) ? {1'b1, ERR_RDATA} : {1'b0, m_word(addr, burst)};
    for (int j = 0; j <= exp_j + 3; j++) begin
      total++;
      if ({bus.app_en_o, bus.resp_valid_o} !== {1'b0, (j == exp_j)}) begin
        bad++;
        $display("FAIL %s rd_wait %0d: got en=%b rv=%b want 0 %b", tag, j,
                 bus.app_en_o, bus.resp_valid_o, (j == exp_j));
      end
      if (j == exp_j) begin
        total++;
        if ({bus.resp_err_o, bus.resp_rdata_o} !== exp_resp) begin
          bad++;
          $display("FAIL %s rd_resp: got err=%b rdata=%h want err=%b rdata=%h", tag,
                   bus.resp_err_o, bus.resp_rdata_o, exp_resp[32], exp_resp[31:0]);
        end
      end
      bus.app_rd_data_valid_i = (j == dv);
      bus.app_rd_data_i       = (j == dv) ? burst : {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end
    bus.app_rd_data_valid_i = 1'b0;
  endtask

  task automatic test_write_basic();
    do_write(32'h0000_0104, 32'hA5A5_1234, 4'b0011, 0, 0, -1, "wr_basic");
  endtask

  task automatic test_write_stall();
    do_write(32'h0123_4568, 32'h0BAD_F00D, 4'b1101, 2, 5, -1, "wr_stall");
    do_write(32'h0FFF_FFFC, 32'h1357_9BDF, 4'b1000, 4, 1, -1, "wr_cmd_late");
  endtask

  task automatic test_read_lane();
    logic [127:0] d;
    bit           ok;
    d = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    wait_ready(ok);
    if (!ok) return;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 32'h0000_002C;
    step();
    bus.req_valid_i = 1'b0;
    bus.app_rdy_i   = 1'b1;
    step();
    bus.app_rdy_i           = 1'b0;
    bus.app_rd_data_i       = d;
    bus.app_rd_data_valid_i = 1'b1;
    step();
    bus.app_rd_data_valid_i = 1'b0;
    total++;
    if ({bus.resp_valid_o, bus.resp_err_o, bus.resp_rdata_o} !== {2'b10, 32'h4444_4444}) begin
      bad++;
      $display("FAIL rd_lane3: got rv=%b err=%b rdata=%h want 1 0 44444444",
               bus.resp_valid_o, bus.resp_err_o, bus.resp_rdata_o);
    end
  endtask

  task automatic test_read_timeout();
    do_read(32'h0000_0010, 0, RD_TO + 1, "rd_timeout");
    do_read(32'h0000_0024, 1, RD_TO - 1, "rd_edge_data_wins");
    do_read(32'h0000_0038, 3, 0, "rd_fast");
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_write($urandom(), $urandom(), 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), -1, "wr_rand");
      else
        do_read($urandom(), int'($urandom_range(0, 4)), int'($urandom_range(0, 8)), "rd_rand");
    end
  endtask

  task automatic test_calib_drop();
    do_write(32'h0000_0200, 32'hCAFE_0001, 4'b1111, 3, 2, 1, "wr_cal_drop");
    step();
    total++;
    if (bus.req_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL cal_drop_hold: got rdy=%b want 0", bus.req_ready_o);
    end
    bus.calib_done_i = 1'b1;
    step();
    total++;
    if (bus.req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL cal_drop_return: got rdy=%b want 1", bus.req_ready_o);
    end
    bus.calib_done_i = 1'b0;
    step();
    total++;
    if (bus.req_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL cal_drop_idle: got rdy=%b want 0", bus.req_ready_o);
    end
    bus.calib_done_i = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 32'h0000_0048;
    step();
    bus.req_valid_i = 1'b0;
    bus.app_rdy_i   = 1'b1;
    step();
    bus.app_rdy_i = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.req_ready_o, bus.resp_valid_o, bus.resp_err_o, bus.app_en_o, bus.app_wdf_wren_o,
         bus.app_cmd_o} !== 8'd0 || bus.app_addr_o !== 28'd0 || bus.app_wdf_mask_o !== 16'hFFFF) begin
      bad++;
      $display("FAIL async_reset: got rdy=%b rv=%b en=%b cmd=%b addr=%h mask=%h want 0 0 0 000 0 FFFF",
               bus.req_ready_o, bus.resp_valid_o, bus.app_en_o, bus.app_cmd_o,
               bus.app_addr_o, bus.app_wdf_mask_o);
    end
    bus.app_rd_data_valid_i = 1'b1;
    bus.app_rd_data_i       = {4{32'h7777_7777}};
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.resp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold %0d: got rv=%b rdy=%b want 0 0", i, bus.resp_valid_o, bus.req_ready_o);
      end
    end
    rst_n                   = 1'b1;
    bus.app_rd_data_valid_i = 1'b0;
    step();
    total++;
    if (bus.req_ready_o !== 1'b1 || bus.resp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got rdy=%b rv=%b want 1 0", bus.req_ready_o, bus.resp_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_calib_gate();
    test_write_basic();
    test_write_stall();
    test_read_lane();
    test_read_timeout();
    test_random();
    test_calib_drop();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
